// File: rtl/memory_kernel_stream.sv
// Kernel window streamer: local buffer plus a row sequencer that
// packs rowCount windows of inputWidth elements into lane vectors.
module memory_kernel_stream #(
   parameter int MaxWidth = 9,
   parameter int Depth = 32,
   parameter int DataWidth = 8,
   parameter int RowWidth = 8,
   localparam int AddrWidth = $clog2(Depth),
   localparam int LenWidth = $clog2(MaxWidth + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          writeEn,
   input  logic [AddrWidth-1:0]          writeAddr,
   input  logic [DataWidth-1:0]          dataIn,
   input  logic                          routeEn,
   input  logic [AddrWidth-1:0]          startAddr,
   input  logic [LenWidth-1:0]           inputWidth,
   input  logic [RowWidth-1:0]           rowCount,
   input  logic [AddrWidth-1:0]          rowStride,
   input  logic                          outReady,
   output logic                          outValid,
   output logic [MaxWidth*DataWidth-1:0] dataOut,
   output logic                          busy,
   output logic                          finished,
   output logic [2:0]                    state
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      LAST = 3'd2,
      OUT  = 3'd3,
      DONE = 3'd4
   } stateT;

   localparam logic [LenWidth-1:0] MaxLen =
      LenWidth'(MaxWidth);

   stateT curState;
   stateT nextState;

   logic [DataWidth-1:0] mem [Depth];
   logic [DataWidth-1:0] lanes [MaxWidth];
   logic [DataWidth-1:0] rdData;
   logic [LenWidth-1:0]  rdLane;
   logic                 rdPend;

   logic [AddrWidth-1:0] rowBase;
   logic [AddrWidth-1:0] strideQ;
   logic [RowWidth-1:0]  rowsLeft;
   logic [LenWidth-1:0]  widthQ;
   logic [LenWidth-1:0]  kCnt;

   logic [LenWidth-1:0]  effW;
   logic [AddrWidth-1:0] rdAddr;
   logic                 emptyJob;
   logic                 lastRead;

   assign effW = (inputWidth > MaxLen) ? MaxLen : inputWidth;
   assign emptyJob = (effW == '0) || (rowCount == '0);
   assign lastRead = (kCnt == widthQ - LenWidth'(1));
   assign rdAddr = rowBase + AddrWidth'(kCnt);

   assign state = curState;

   // Buffer write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (writeEn) begin
         mem[writeAddr] <= dataIn;
      end
   end

   // Next-state decode and handshake-facing outputs.
   always_comb begin
      nextState = curState;
      outValid = 1'b0;
      busy = 1'b1;
      unique case (curState)
         IDLE: begin
            busy = 1'b0;
            if (routeEn) begin
               nextState = emptyJob ? DONE : READ;
            end
         end
         READ: begin
            if (lastRead) begin
               nextState = LAST;
            end
         end
         LAST: begin
            nextState = OUT;
         end
         OUT: begin
            outValid = 1'b1;
            if (outReady) begin
               nextState = (rowsLeft != '0) ? READ : DONE;
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State register, job latch, read sequencing and lane capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         curState <= IDLE;
         finished <= 1'b0;
         rowBase  <= '0;
         strideQ  <= '0;
         rowsLeft <= '0;
         widthQ   <= '0;
         kCnt     <= '0;
         rdData   <= '0;
         rdLane   <= '0;
         rdPend   <= 1'b0;
         lanes    <= '{default: '0};
      end else begin
         curState <= nextState;
         finished <= (curState == DONE);
         case (curState)
            IDLE: begin
               if (routeEn) begin
                  rowBase  <= startAddr;
                  strideQ  <= rowStride;
                  rowsLeft <= rowCount - RowWidth'(1);
                  widthQ   <= effW;
                  kCnt     <= '0;
                  rdPend   <= 1'b0;
                  lanes    <= '{default: '0};
               end
            end
            READ: begin
               rdData <= mem[rdAddr];
               rdLane <= kCnt;
               rdPend <= 1'b1;
               kCnt   <= kCnt + LenWidth'(1);
               if (rdPend) begin
                  lanes[rdLane] <= rdData;
               end
            end
            LAST: begin
               if (rdPend) begin
                  lanes[rdLane] <= rdData;
               end
               rdPend <= 1'b0;
            end
            OUT: begin
               if (outReady && rowsLeft != '0) begin
                  rowBase  <= rowBase + strideQ;
                  rowsLeft <= rowsLeft - RowWidth'(1);
                  kCnt     <= '0;
                  lanes    <= '{default: '0};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Pack lanes into the output vector, lane 0 in the low bits.
   always_comb begin
      dataOut = '0;
      for (int k = 0; k < MaxWidth; k++) begin
         dataOut[k*DataWidth +: DataWidth] = lanes[k];
      end
   end

endmodule
